reorder_buffer: RTL and testbench
=================================

# reorder_buffer

16-entry circular reorder buffer for the Tomasulo core. It sits between issue and the register file. It allocates an entry per issued instruction, captures results broadcast on the CDB, and retires entries in order at the head. Retirement writes the register file, releases stores to the LSB, and raises a pipeline flush on a mispredicted branch.

## Interface
Parameters and constants:
- ROB_SIZE, 16: number of entries. Must be a power of two, matching `ROBINDEX` width 4.

Ports:
- clk  in  1: clock.
- rst  in  1: asynchronous, active-low reset.
- rdy  in  1: global enable. When 0, all state is frozen.
- issue_valid  in  1: allocate an entry this cycle.
- issue_rd  in  `REGINDEX`: destination register. 0 means no register write.
- issue_is_branch  in  1: entry is a conditional branch or jalr.
- issue_is_store  in  1: entry is a store.
- issue_pred_taken  in  1: predictor decision at fetch.
- rob_full  out  1: combinational, count == ROB_SIZE.
- rob_tail_tag  out  `ROBINDEX`: combinational; tag the next issue will receive.
- query_tag1, query_tag2  in  `ROBINDEX`: operand lookup from the decoder.
- query_ready1, query_ready2  out  1: combinational; the entry is busy and its result has arrived.
- query_value1, query_value2  out  `DATALEN`: combinational entry values.
- cdb_valid  in  1: result broadcast.
- cdb_tag  in  `ROBINDEX`: entry the result belongs to.
- cdb_value  in  `DATALEN`: result value (rd value; for jal/jalr this is pc+4).
- cdb_taken  in  1: actual branch outcome.
- cdb_redirect_pc  in  `ADDRLEN`: correct next pc for a branch.
- rob_update_valid  out  1: register pulse, one cycle.
- rob_update_index  out  `REGINDEX`
- rob_update_rename  out  `ROBINDEX`
- rob_updated_value  out  `DATALEN`
- store_commit_valid  out  1: pulse releasing the head store to the LSB.
- store_commit_tag  out  `ROBINDEX`
- flush  out  1: pulse on mispredict retirement.
- flush_pc  out  `ADDRLEN`

## Operation
- Each entry holds: busy, ready, rd, is_branch, is_store, pred_taken, taken, value, redirect_pc. Pointers are head and tail (4 bits, wrap mod 16); count is 5 bits.
- Issue: if issue_valid && !rob_full, write the entry at tail (busy=1, ready=0), then tail+1 and count+1. Issue while full is ignored.
- CDB: if cdb_valid and the entry at cdb_tag is busy, set ready=1 and latch value, taken and redirect_pc. A CDB write to a non-busy entry is ignored.
- Commit, at most one per cycle: if count != 0 and the head entry is ready:
  - Non-store with rd != 0: pulse rob_update_valid with rd, the head tag and the value.
  - Store: pulse store_commit_valid with the head tag.
  - Branch where taken != pred_taken: pulse flush with flush_pc = redirect_pc.
  - In all cases: clear busy, head+1, count-1.
- Flush: on the same edge that commits the mispredicted head, clear every busy bit and set head = tail = count = 0. Any issue in that cycle is discarded. The branch's own rd write (jalr) still commits.
- Simultaneous issue and commit: count is unchanged. rob_full uses the registered count, so issue is blocked when full even if a commit happens in the same cycle.
- Simultaneous CDB write to the head and commit of the head: the entry is not ready yet, so commit waits for the next cycle.
- rdy=0: no state update; all pulse outputs go to 0 on the next edge.

## Timing
- Reset: every output register is 0; head, tail and count are 0; all busy bits are 0.
- Issue to the tag being visible at rob_tail_tag: 0 cycles (combinational). The entry becomes queryable after the issue edge.
- CDB to query_ready: 1 cycle (registered). With ROB_CDB_BYPASS_EN this is 0 cycles.
- CDB to commit pulse: earliest 2 edges. The ready bit is set on edge N, the commit decision is made in cycle N, and the pulse is registered on edge N+1.
- All pulse outputs are registered and high for exactly one cycle.
- Reset asserted mid-operation clears everything immediately, including any pulse in flight.

## Configuration
- ROB_CDB_BYPASS_EN defined: a query whose tag matches a busy entry with cdb_valid && cdb_tag == query_tag returns ready=1 and value=cdb_value in the same cycle.
- ROB_CDB_BYPASS_EN undefined: queries reflect registered state only.

## Structure
- `define.v` holds ROB_SIZE, `ROBINDEX`, `REGINDEX`, `DATALEN` and `ADDRLEN`. No new shared typedefs are needed.
- Single module with no sub-module. The entry array is flat per-field arrays.

## Test plan
- Reset, then issue 16 entries with no CDB -> rob_full=1 after the 16th edge; a 17th issue leaves tail at 0 and count at 16.
- Issue rd=5 at tag 0, then CDB tag0 value 0x1234 -> rob_update_valid pulse with index 5, rename 0, value 0x1234, exactly one cycle wide.
- Branch at tag 2 with pred_taken=0, CDB taken=1 and redirect 0x100, two younger entries busy -> flush=1 with flush_pc=0x100; next cycle count=0, rob_full=0, tail_tag=0.
- Wrap-around: commit and issue 20 entries in steady state -> tags go 15 then 0, and commits stay in program order.
- Query tag 3 in the same cycle as CDB tag3 value 7 -> ready=1 and value 7 with ROB_CDB_BYPASS_EN defined; ready=0 without it.
- rdy=0 for 3 cycles with a ready head -> no commit pulse and no pointer change; the pulse appears on the first edge after rdy returns to 1.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// ============================================================================
// reorder_buffer_pkg : shared sizes for the reorder buffer slice
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package reorder_buffer_pkg;
  localparam int ROB_SIZE = 16;
  localparam int ROBINDEX = 4;
  localparam int REGINDEX = 5;
  localparam int DATALEN  = 32;
  localparam int ADDRLEN  = 32;

  localparam logic [ROBINDEX:0] ROB_FULL_COUNT = ROB_SIZE[ROBINDEX:0];
endpackage

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
// reorder_buffer : 16-entry in-order retirement buffer (optional macro ROB_CDB_BYPASS_EN)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                issue_valid,
  input  logic [REGINDEX-1:0] issue_rd,
  input  logic                issue_is_branch,
  input  logic                issue_is_store,
  input  logic                issue_pred_taken,
  output logic                rob_full,
  output logic [ROBINDEX-1:0] rob_tail_tag,
  input  logic [ROBINDEX-1:0] query_tag1,
  input  logic [ROBINDEX-1:0] query_tag2,
  output logic                query_ready1,
  output logic                query_ready2,
  output logic [DATALEN-1:0]  query_value1,
  output logic [DATALEN-1:0]  query_value2,
  input  logic                cdb_valid,
  input  logic [ROBINDEX-1:0] cdb_tag,
  input  logic [DATALEN-1:0]  cdb_value,
  input  logic                cdb_taken,
  input  logic [ADDRLEN-1:0]  cdb_redirect_pc,
  output logic                rob_update_valid,
  output logic [REGINDEX-1:0] rob_update_index,
  output logic [ROBINDEX-1:0] rob_update_rename,
  output logic [DATALEN-1:0]  rob_updated_value,
  output logic                store_commit_valid,
  output logic [ROBINDEX-1:0] store_commit_tag,
  output logic                flush,
  output logic [ADDRLEN-1:0]  flush_pc
);

  logic                r_busy      [ROB_SIZE];
  logic                r_ready     [ROB_SIZE];
  logic [REGINDEX-1:0] r_rd        [ROB_SIZE];
  logic                r_is_branch [ROB_SIZE];
  logic                r_is_store  [ROB_SIZE];
  logic                r_pred      [ROB_SIZE];
  logic                r_taken     [ROB_SIZE];
  logic [DATALEN-1:0]  r_value     [ROB_SIZE];
  logic [ADDRLEN-1:0]  r_redirect  [ROB_SIZE];

  logic [ROBINDEX-1:0] r_head;
  logic [ROBINDEX-1:0] r_tail;
  logic [ROBINDEX:0]   r_count;

  logic w_commit;
  logic w_flush;
  logic w_issue;
  logic w_cdb_hit;

  assign rob_full     = (r_count == ROB_FULL_COUNT);
  assign rob_tail_tag = r_tail;

  // Commit only sees the registered ready bit, so a same-edge CDB write to the head waits a cycle.
  always_comb begin
    w_commit  = rdy && (r_count != '0) && r_ready[r_head];
    w_flush   = w_commit && r_is_branch[r_head] && (r_taken[r_head] != r_pred[r_head]);
    w_issue   = rdy && issue_valid && !rob_full && !w_flush;
    w_cdb_hit = rdy && cdb_valid && r_busy[cdb_tag];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_busy[i]  <= 1'b0;
        r_ready[i] <= 1'b0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_busy[i] <= 1'b0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (w_cdb_hit) begin
        r_ready[cdb_tag] <= 1'b1;
      end
      if (w_commit) begin
        r_busy[r_head] <= 1'b0;
      end
      if (w_issue) begin
        r_busy[r_tail]  <= 1'b1;
        r_ready[r_tail] <= 1'b0;
      end
      r_head  <= r_head + {{(ROBINDEX-1){1'b0}}, w_commit};
      r_tail  <= r_tail + {{(ROBINDEX-1){1'b0}}, w_issue};
      r_count <= r_count + {{ROBINDEX{1'b0}}, w_issue} - {{ROBINDEX{1'b0}}, w_commit};
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_rd[r_tail]        <= issue_rd;
      r_is_branch[r_tail] <= issue_is_branch;
      r_is_store[r_tail]  <= issue_is_store;
      r_pred[r_tail]      <= issue_pred_taken;
    end
    if (w_cdb_hit) begin
      r_value[cdb_tag]    <= cdb_value;
      r_taken[cdb_tag]    <= cdb_taken;
      r_redirect[cdb_tag] <= cdb_redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rob_update_valid   <= 1'b0;
      rob_update_index   <= '0;
      rob_update_rename  <= '0;
      rob_updated_value  <= '0;
      store_commit_valid <= 1'b0;
      store_commit_tag   <= '0;
      flush              <= 1'b0;
      flush_pc           <= '0;
    end else begin
      rob_update_valid   <= w_commit && !r_is_store[r_head] && (r_rd[r_head] != '0);
      store_commit_valid <= w_commit && r_is_store[r_head];
      flush              <= w_flush;
      if (w_commit) begin
        rob_update_index  <= r_rd[r_head];
        rob_update_rename <= r_head;
        rob_updated_value <= r_value[r_head];
        store_commit_tag  <= r_head;
        flush_pc          <= r_redirect[r_head];
      end
    end
  end

  always_comb begin
    query_ready1 = r_busy[query_tag1] && r_ready[query_tag1];
    query_value1 = r_value[query_tag1];
    query_ready2 = r_busy[query_tag2] && r_ready[query_tag2];
    query_value2 = r_value[query_tag2];
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && (cdb_tag == query_tag1) && r_busy[query_tag1]) begin
      query_ready1 = 1'b1;
      query_value1 = cdb_value;
    end
    if (cdb_valid && (cdb_tag == query_tag2) && r_busy[query_tag2]) begin
      query_ready2 = 1'b1;
      query_value2 = cdb_value;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// tb_reorder_buffer : directed + random checks against a queue-based ROB model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_is_branch = 1'b0;
  logic        issue_is_store = 1'b0;
  logic        issue_pred_taken = 1'b0;
  logic        rob_full;
  logic [3:0]  rob_tail_tag;
  logic [3:0]  query_tag1 = '0;
  logic [3:0]  query_tag2 = '0;
  logic        query_ready1, query_ready2;
  logic [31:0] query_value1, query_value2;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic        cdb_taken = 1'b0;
  logic [31:0] cdb_redirect_pc = '0;
  logic        rob_update_valid;
  logic [4:0]  rob_update_index;
  logic [3:0]  rob_update_rename;
  logic [31:0] rob_updated_value;
  logic        store_commit_valid;
  logic [3:0]  store_commit_tag;
  logic        flush;
  logic [31:0] flush_pc;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
    .issue_is_store(issue_is_store), .issue_pred_taken(issue_pred_taken),
    .rob_full(rob_full), .rob_tail_tag(rob_tail_tag),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_value1(query_value1), .query_value2(query_value2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .cdb_redirect_pc(cdb_redirect_pc),
    .rob_update_valid(rob_update_valid), .rob_update_index(rob_update_index),
    .rob_update_rename(rob_update_rename), .rob_updated_value(rob_updated_value),
    .store_commit_valid(store_commit_valid), .store_commit_tag(store_commit_tag),
    .flush(flush), .flush_pc(flush_pc)
  );

  // Reference: program-order list of in-flight instructions; head is q[0].
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    bit          br;
    bit          st;
    bit          pred;
    bit          done;
    bit          taken;
    logic [31:0] val;
    logic [31:0] pc;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_tail = '0;
  int         total = 0;
  int         bad = 0;
  bit         qrand = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input logic [3:0] t);
    foreach (q[i]) if (q[i].tag == t) return i;
    return -1;
  endfunction

  task automatic qchk(input string nm, input logic [3:0] t, input logic r_obs, input logic [31:0] v_obs);
    int k;
    logic er;
    logic [31:0] ev;
    k = find(t);
    er = 1'b0;
    ev = '0;
    if (k >= 0) begin
      er = q[k].done;
      ev = q[k].val;
`ifdef ROB_CDB_BYPASS_EN
      if (cdb_valid && cdb_tag == t) begin
        er = 1'b1;
        ev = cdb_value;
      end
`endif
    end
    chk({nm, "_ready"}, r_obs, er);
    if (er) chk({nm, "_value"}, v_obs, ev);
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    rdy         = 1'b1;
  endtask

  task automatic set_issue(input logic [4:0] rd, input bit br, input bit st, input bit pred);
    issue_valid = 1'b1;
    issue_rd = rd;
    issue_is_branch = br;
    issue_is_store = st;
    issue_pred_taken = pred;
  endtask

  task automatic set_cdb(input logic [3:0] t, input logic [31:0] v, input bit tk, input logic [31:0] pc);
    cdb_valid = 1'b1;
    cdb_tag = t;
    cdb_value = v;
    cdb_taken = tk;
    cdb_redirect_pc = pc;
  endtask

  // One clock: check combinational outputs, predict pulses, clock, check, advance model.
  task automatic step();
    bit   com, full, e_upd, e_st, e_fl;
    ent_t h;
    int   k;
    if (qrand) begin
      query_tag1 = 4'($urandom_range(15));
      query_tag2 = 4'($urandom_range(15));
    end
    #1;
    chk("rob_full", rob_full, q.size() == 16);
    chk("tail_tag", rob_tail_tag, m_tail);
    qchk("q1", query_tag1, query_ready1, query_value1);
    qchk("q2", query_tag2, query_ready2, query_value2);
    com = rdy && q.size() != 0 && q[0].done;
    h = com ? q[0] : '{default: 0};
    e_upd = com && !h.st && h.rd != 0;
    e_st  = com && h.st;
    e_fl  = com && h.br && (h.taken != h.pred);
    @(posedge clk);
    #1;
    chk("upd_valid", rob_update_valid, e_upd);
    if (e_upd) begin
      chk("upd_index", rob_update_index, h.rd);
      chk("upd_rename", rob_update_rename, h.tag);
      chk("upd_value", rob_updated_value, h.val);
    end
    chk("st_valid", store_commit_valid, e_st);
    if (e_st) chk("st_tag", store_commit_tag, h.tag);
    chk("flush", flush, e_fl);
    if (e_fl) chk("flush_pc", flush_pc, h.pc);
    if (rdy) begin
      k = find(cdb_tag);
      if (cdb_valid && k >= 0) begin
        q[k].done  = 1'b1;
        q[k].val   = cdb_value;
        q[k].taken = cdb_taken;
        q[k].pc    = cdb_redirect_pc;
      end
      full = (q.size() == 16);
      if (com) void'(q.pop_front());
      if (e_fl) begin
        q.delete();
        m_tail = '0;
      end else if (issue_valid && !full) begin
        q.push_back('{tag: m_tail, rd: issue_rd, br: issue_is_branch, st: issue_is_store,
                      pred: issue_pred_taken, done: 1'b0, taken: 1'b0, val: '0, pc: '0});
        m_tail = m_tail + 4'd1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_upd_valid", rob_update_valid, 1'b0);
    chk("rst_upd_value", rob_updated_value, 32'h0);
    chk("rst_st_valid", store_commit_valid, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_flush_pc", flush_pc, 32'h0);
    chk("rst_full", rob_full, 1'b0);
    chk("rst_tail", rob_tail_tag, 4'd0);
    q.delete();
    m_tail = '0;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit seen;
    do_reset();

    // Fill all 16 entries, then a 17th issue must be ignored.
    for (int i = 0; i < 16; i++) begin
      set_issue(5'(i + 1), 1'b0, 1'b0, 1'b0);
      step();
    end
    step();
    idle();
    step();

    // Single register write-back.
    do_reset();
    set_issue(5'd5, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    set_cdb(4'd0, 32'h1234, 1'b0, 32'h0);
    step();
    idle();
    step();
    chk("wb_index", rob_update_index, 5'd5);
    chk("wb_value", rob_updated_value, 32'h1234);
    step();

    // Mispredicted branch at tag 2 with two younger entries.
    do_reset();
    set_issue(5'd1, 1'b0, 1'b0, 1'b0); step();
    set_issue(5'd2, 1'b0, 1'b1, 1'b0); step();
    set_issue(5'd3, 1'b1, 1'b0, 1'b0); step();
    set_issue(5'd4, 1'b0, 1'b0, 1'b0); step();
    set_issue(5'd6, 1'b0, 1'b0, 1'b0); step();
    idle();
    set_cdb(4'd0, 32'hA, 1'b0, 32'h0);    step();
    set_cdb(4'd1, 32'hB, 1'b0, 32'h0);    step();
    set_cdb(4'd2, 32'hC, 1'b1, 32'h100);  step();
    idle();
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step();
      seen = flush;
    end
    chk("flush_seen", seen, 1'b1);
    chk("flush_pc_dir", flush_pc, 32'h100);
    step();

    // Steady-state wrap: issue every cycle, complete the oldest.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      set_issue(5'($urandom_range(31)), 1'b0, 1'b0, 1'b0);
      if (q.size() != 0) set_cdb(q[0].tag, $urandom, 1'b0, 32'h0);
      else cdb_valid = 1'b0;
      step();
    end

    // Query in the same cycle as the CDB write.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_issue(5'(i + 1), 1'b0, 1'b0, 1'b0);
      step();
    end
    idle();
    query_tag1 = 4'd3;
    query_tag2 = 4'd2;
    set_cdb(4'd3, 32'd7, 1'b0, 32'h0);
    step();
    idle();
    step();

    // rdy low for three cycles with a ready head.
    do_reset();
    set_issue(5'd9, 1'b0, 1'b0, 1'b0); step();
    idle();
    set_cdb(4'd0, 32'h55, 1'b0, 32'h0); step();
    idle();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rdy = 1'b1;
    step();
    step();

    // Random traffic with occasional mid-run reset.
    do_reset();
    qrand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      rdy = ($urandom_range(9) != 0);
      if ($urandom_range(9) < 7) begin
        case ($urandom_range(9))
          0:       set_issue(5'($urandom_range(31)), 1'b1, 1'b0, 1'($urandom_range(1)));
          1, 2:    set_issue(5'($urandom_range(31)), 1'b0, 1'b1, 1'b0);
          3:       set_issue(5'd0, 1'b0, 1'b0, 1'b0);
          default: set_issue(5'($urandom_range(31)), 1'b0, 1'b0, 1'b0);
        endcase
      end else issue_valid = 1'b0;
      if ($urandom_range(1) == 1) begin
        if (q.size() != 0 && $urandom_range(3) != 0) begin
          int k;
          k = int'($urandom_range(q.size() - 1));
          set_cdb(q[k].tag, $urandom,
                  ($urandom_range(3) == 0) ? !q[k].pred : q[k].pred, $urandom);
        end else set_cdb(4'($urandom_range(15)), $urandom, 1'($urandom_range(1)), $urandom);
      end else cdb_valid = 1'b0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
